// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM controller types: refresh FSM state encoding and pending-count width.
package sdram_ctrl_pkg;

  localparam int PEND_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_TRC  = 2'd2
  } ref_state_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval down-counter: one-cycle tick every REF_INTERVAL cycles once init is done.
// Tick is combinational from the counter register; held at reload while init_done_i is low.
module sdram_refresh_timer #(
  parameter int REF_INTERVAL = 781
) (
  input  logic sdram_clk,
  input  logic sdram_rst,
  input  logic init_done_i,
  output logic tick_o
);

  localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (!init_done_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q == '0) begin
      tick_o = 1'b1;
      cnt_d  = RELOAD;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) cnt_q <= RELOAD;
    else           cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sdram_refresh_sched.sv
// SDRAM refresh scheduler: tracks owed refreshes, requests REF one cycle after the IDLE condition, holds tRC.
// SDRAM_REFRESH_BURST_EN: drain owed refreshes back-to-back from TRC instead of returning to IDLE.
module sdram_refresh_sched
  import sdram_ctrl_pkg::*;
#(
  parameter int REF_INTERVAL  = 781,
  parameter int MAX_POSTPONE  = 8,
  parameter int URGENT_THRESH = 6,
  parameter int tRC           = 7
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst,
  input  logic              init_done_i,
  input  logic              idle_i,
  output logic              ref_req_o,
  input  logic              ref_ack_i,
  output logic              ref_urgent_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              ovf_o
);

  localparam int TRC_W = (tRC > 1) ? $clog2(tRC) : 1;
  localparam logic [TRC_W-1:0]  TRC_LOAD = TRC_W'(tRC - 1);
  localparam logic [PEND_W-1:0] MAX_P    = PEND_W'(MAX_POSTPONE);
  localparam logic [PEND_W-1:0] URG_P    = PEND_W'(URGENT_THRESH);

  ref_state_e        state_q, state_d;
  logic [TRC_W-1:0]  trc_q, trc_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              ovf_q, ovf_d;
  logic              tick;
  logic              ack_acc;

  sdram_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_timer (
    .sdram_clk  (sdram_clk),
    .sdram_rst  (sdram_rst),
    .init_done_i(init_done_i),
    .tick_o     (tick)
  );

  // An ack only counts while a request is actually outstanding.
  assign ack_acc = ref_ack_i && (state_q == ST_REQ);

  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (!init_done_i) begin
      pending_d = '0;
    end else if (tick && !ack_acc) begin
      if (pending_q >= MAX_P) ovf_d = 1'b1;
      else                    pending_d = pending_q + PEND_W'(1);
    end else if (ack_acc && !tick) begin
      pending_d = pending_q - PEND_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    trc_d   = trc_q;
    if (!init_done_i) begin
      state_d = ST_IDLE;
      trc_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((pending_q != '0) && (idle_i || (pending_q >= URG_P))) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (ref_ack_i) begin
            state_d = ST_TRC;
            trc_d   = TRC_LOAD;
          end
        end
        ST_TRC: begin
          if (trc_q == '0) begin
`ifdef SDRAM_REFRESH_BURST_EN
            state_d = (pending_q != '0) ? ST_REQ : ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            trc_d = trc_q - TRC_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state_q   <= ST_IDLE;
      trc_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      trc_q     <= trc_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  // Outputs decode registers only, so reset clears them without a clock edge.
  assign ref_req_o    = (state_q == ST_REQ);
  assign busy_o       = (state_q == ST_TRC);
  assign ref_urgent_o = (pending_q >= URG_P) || busy_o;
  assign pending_o    = pending_q;
  assign ovf_o        = ovf_q;

endmodule

// File: doc/sdram_refresh_sched.md
SDRAM_REFRESH_SCHED -- requirements
Module: sdram_refresh_sched

Interface
REQ-001 SHALL have parameter REF_INTERVAL, default 781, meaning sdram_clk cycles per refresh tick (64 ms / 8192 rows at 100 MHz).
REQ-002 SHALL have parameter MAX_POSTPONE, default 8, meaning maximum owed refreshes held (1..15).
REQ-003 SHALL have parameter URGENT_THRESH, default 6, meaning owed count at which refresh becomes urgent (1..MAX_POSTPONE).
REQ-004 SHALL have parameter tRC, default 7, meaning REF-to-command cycles after an acknowledged refresh.
REQ-005 SHALL have port sdram_clk, input, 1, the single clock of the block.
REQ-006 SHALL have port sdram_rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port init_done_i, input, 1, meaning SDRAM power-up/mode-register sequence is complete.
REQ-008 SHALL have port idle_i, input, 1, meaning the controller has no access in flight.
REQ-009 SHALL have port ref_req_o, output, 1, meaning refresh requested.
REQ-010 SHALL have port ref_ack_i, input, 1, meaning the controller issued REF this cycle.
REQ-011 SHALL have port ref_urgent_o, output, 1, meaning the controller must not start new accesses.
REQ-012 SHALL have port busy_o, output, 1, meaning a tRC window is active.
REQ-013 SHALL have port pending_o, output, 4, meaning the owed refresh count.
REQ-014 SHALL have port ovf_o, output, 1, meaning sticky overflow (a tick was lost).

Function
REQ-015 SHALL hold the interval counter at REF_INTERVAL-1 and pending at 0 while init_done_i=0.
REQ-016 SHALL count the interval counter down each cycle while init_done_i=1, and emit a one-cycle tick and reload REF_INTERVAL-1 at 0.
REQ-017 SHALL increment pending on tick, decrement on accepted ack, and leave it unchanged when both occur in the same cycle.
REQ-018 SHALL hold pending at MAX_POSTPONE and set ovf_o on a tick at MAX_POSTPONE without ack; ovf_o clears only on reset.
REQ-019 SHALL implement FSM IDLE, REQ, TRC.
REQ-020 SHALL transition IDLE->REQ when pending>0 and (idle_i=1 or pending>=URGENT_THRESH).
REQ-021 SHALL assert ref_req_o exactly in REQ, and transition REQ->TRC on ref_ack_i=1.
REQ-022 SHALL ignore ref_ack_i outside REQ, with no pending change.
REQ-023 SHALL hold TRC for exactly tRC cycles with busy_o=1, then exit.
REQ-024 SHALL drive ref_urgent_o = (pending>=URGENT_THRESH) or (state==TRC), combinationally from registers.
REQ-025 SHALL, on init_done_i falling, return the FSM to IDLE, with pending=0 and busy_o=0 on the next cycle.
REQ-026 SHALL give request latency: ref_req_o high on the cycle after the IDLE condition is met.

Reset
REQ-027 SHALL, on sdram_rst, asynchronously set state=IDLE, interval counter=REF_INTERVAL-1, pending=0, ref_req_o=0, ref_urgent_o=0, busy_o=0, ovf_o=0.

Configuration
REQ-028 SHALL, with SDRAM_REFRESH_BURST_EN defined, exit TRC directly to REQ when pending>0 regardless of idle_i, draining all owed refreshes back-to-back.
REQ-029 SHALL, without SDRAM_REFRESH_BURST_EN, always exit TRC to IDLE and re-evaluate REQ-020.

Structure
REQ-030 SHALL take its state enum and pending width constant (4) from shared package sdram_ctrl_pkg.
REQ-031 SHALL implement the interval counter and tick as sub-module sdram_refresh_timer; the FSM stays in the top.

Verification (REF_INTERVAL=16, MAX_POSTPONE=8, URGENT_THRESH=6, tRC=7)
REQ-032 SHALL cover: init_done_i=1, idle_i=1, ack 2 cycles after req -> first ref_req_o at cycle 17, busy_o high exactly 7 cycles, pending returns 0.
REQ-033 SHALL cover: idle_i=0 for 100 cycles -> pending reaches 6 at cycle 96, ref_urgent_o=1 and ref_req_o=1 the next cycle.
REQ-034 SHALL cover: idle_i=0, no ack for 160 cycles -> pending saturates at 8, ovf_o=1 and remains 1 until sdram_rst.
REQ-035 SHALL cover: ack coincident with tick while pending=3 -> pending stays 3.
REQ-036 SHALL cover: with SDRAM_REFRESH_BURST_EN, pending=4 then idle_i=0 -> 4 REQ/TRC pairs back-to-back; without the macro, exactly 1 pair.
REQ-037 SHALL cover: sdram_rst asserted mid-TRC -> all outputs 0 and pending_o=0 immediately, without waiting for a clock edge.
